irq_preempt_ctrl: RTL and testbench
===================================

Name: irq_preempt_ctrl

Overview:
- Sits between the OBI-mapped interrupt controller (highest pending line's id/level/heti/nest) and the core's interrupt interface.
- Forwards an interrupt request only when it may preempt the running context.
- Tracks nesting in a level stack: push on core take, pop on return from handler.
- Returns a one-cycle claim pulse to the controller so the taken line's pending bit clears.

Parameters:
- NrIrqLines, 64, number of interrupt lines; IrqWidth = $clog2(NrIrqLines).
- NrIrqPrios, 32, number of priority levels; PrioWidth = $clog2(NrIrqPrios).
- NestDepth, 8, maximum nesting depth (entries in the level stack); DepthWidth = $clog2(NestDepth+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- irq_valid_i  in  1  controller has a pending and enabled interrupt
- irq_id_i  in  IrqWidth  id of the winning line
- irq_level_i  in  PrioWidth  priority of the winning line
- irq_heti_i  in  1  winning line is HETI type
- irq_nest_i  in  1  winning line's handler may itself be preempted
- irq_ack_o  out  1  claim pulse to controller
- irq_ack_id_o  out  IrqWidth  id being claimed
- mthresh_i  in  PrioWidth  software priority threshold
- core_irq_req_o  out  1  interrupt request to core
- core_irq_id_o  out  IrqWidth  requested id
- core_irq_level_o  out  PrioWidth  requested level
- core_irq_heti_o  out  1  requested line is HETI
- core_irq_ack_i  in  1  core takes the current request
- core_mret_i  in  1  core returns from the innermost handler
- cur_level_o  out  PrioWidth  level of top stack entry, 0 when stack empty
- depth_o  out  DepthWidth  current nesting depth
- underflow_o  out  1  sticky: mret seen with empty stack

Behaviour:
- Reset (rst_i high at a clock edge): all outputs 0, state IDLE, stack empty, underflow_o cleared. Applies mid-request or mid-nest; no ack pulse is generated afterwards.
- Stack entry = {level, nest}. Top = entry at depth_o-1.
- eff_level = max(mthresh_i, cur_level_o).
- eligible = irq_valid_i & (irq_level_i > eff_level) & (depth_o < NestDepth) & (depth_o == 0 | top.nest). Comparison is strict: equal level never preempts.
- Request registers {id, level, heti, nest} drive core_irq_*_o directly. All outputs are registered.
- IDLE:
  - if eligible: latch request registers, go REQ.
  - core_irq_req_o rises the cycle after eligible is first seen (1-cycle latency).
- REQ (core_irq_req_o = 1, outputs stable unless retargeted). Priority order:
  1. core_irq_ack_i: push {latched level, latched nest}; set irq_ack_o=1 with irq_ack_id_o = latched id; drop core_irq_req_o; go ACK. depth_o and cur_level_o update in the same cycle irq_ack_o rises (ack cycle + 1).
  2. Else if !eligible: withdraw. core_irq_req_o = 0 next cycle; go IDLE.
  3. Else if irq_level_i > latched level: retarget. Re-latch all request fields; stay in REQ, request held high.
  4. Else hold.
- ACK: irq_ack_o high exactly this one cycle; go IDLE. No new request is evaluated in ACK, so a stale irq_valid_i is never forwarded.
- core_irq_ack_i outside REQ is ignored.
- core_mret_i, in any state:
  - depth_o > 0: pop.
  - depth_o == 0: no change; set underflow_o.
  - A pop during REQ does not withdraw the request.
- core_mret_i and core_irq_ack_i in the same cycle (tail-chain): top entry is replaced by the new entry; depth_o unchanged. If depth_o == 0, push normally and set underflow_o.
- Stack full (depth_o == NestDepth): eligible is forced low, so overflow cannot occur.

Test Plan:
- Basic take: mthresh_i=0, irq_valid_i=1, id=5, level=3, nest=1 at cycle 0 → core_irq_req_o=1 with id 5 at cycle 1. Ack at cycle 3 → irq_ack_o=1, irq_ack_id_o=5 at cycle 4 only; depth_o=1, cur_level_o=3.
- Preempt/no-preempt: with top level 3 nest=1, level 3 arrives → no request; level 4 arrives → request. With top nest=0, level 7 arrives → no request.
- Retarget and withdraw: in REQ with id 2/level 4, id 9/level 6 appears → core_irq_id_o=9, req stays 1. Then irq_valid_i=0 → req=0 next cycle, no ack pulse.
- Threshold: mthresh_i=10, level 10 → no request; level 11 → request.
- Full stack: NestDepth=8, push 8 nesting levels 1..8 → level 9 is not requested. One mret → depth_o=7, cur_level_o=7, level 9 is requested.
- Corner cases: mret at depth 0 → underflow_o=1 and stays 1. Ack+mret same cycle at depth 2 → depth stays 2, top replaced. rst_i asserted in REQ → all outputs 0 next cycle.

Source files
------------

// File: rtl/irq_preempt_ctrl_if.sv
// Controller-side bus of the preemption block: the winning pending line flows in,
// and the claim pulse flows back so the controller can clear that pending bit.
interface irq_preempt_ctrl_if #(
    parameter int unsigned NrIrqLines = 64,
    parameter int unsigned NrIrqPrios = 32,
    localparam int unsigned IrqWidth  = $clog2(NrIrqLines),
    localparam int unsigned PrioWidth = $clog2(NrIrqPrios)
);
    logic                 irq_valid_i;
    logic [IrqWidth-1:0]  irq_id_i;
    logic [PrioWidth-1:0] irq_level_i;
    logic                 irq_heti_i;
    logic                 irq_nest_i;
    logic                 irq_ack_o;
    logic [IrqWidth-1:0]  irq_ack_id_o;

    modport master (
        output irq_valid_i, irq_id_i, irq_level_i, irq_heti_i, irq_nest_i,
        input  irq_ack_o, irq_ack_id_o
    );

    modport slave (
        input  irq_valid_i, irq_id_i, irq_level_i, irq_heti_i, irq_nest_i,
        output irq_ack_o, irq_ack_id_o
    );
endinterface

// File: rtl/irq_preempt_ctrl.sv
// Forwards the controller's winning interrupt to the core only when it may preempt
// the running context, keeping a {level, nest} stack of the nested handlers.
module irq_preempt_ctrl #(
    parameter int unsigned NrIrqLines = 64,
    parameter int unsigned NrIrqPrios = 32,
    parameter int unsigned NestDepth  = 8,
    localparam int unsigned IrqWidth   = $clog2(NrIrqLines),
    localparam int unsigned PrioWidth  = $clog2(NrIrqPrios),
    localparam int unsigned DepthWidth = $clog2(NestDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    irq_preempt_ctrl_if.slave     ctl,
    input  logic [PrioWidth-1:0]  mthresh_i,
    output logic                  core_irq_req_o,
    output logic [IrqWidth-1:0]   core_irq_id_o,
    output logic [PrioWidth-1:0]  core_irq_level_o,
    output logic                  core_irq_heti_o,
    input  logic                  core_irq_ack_i,
    input  logic                  core_mret_i,
    output logic [PrioWidth-1:0]  cur_level_o,
    output logic [DepthWidth-1:0] depth_o,
    output logic                  underflow_o
);
    localparam int unsigned PtrWidth = (NestDepth > 1) ? $clog2(NestDepth) : 1;

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;

    typedef struct packed {
        logic [IrqWidth-1:0]  id;
        logic [PrioWidth-1:0] level;
        logic                 heti;
        logic                 nest;
    } req_t;

    state_e               state_q;
    req_t                 req_q;
    req_t                 req_in;
    logic                 req_valid_q;
    logic                 ack_q;
    logic [IrqWidth-1:0]  ack_id_q;

    logic [PrioWidth-1:0] lvl_q  [NestDepth];
    logic [PrioWidth-1:0] lvl_d  [NestDepth];
    logic                 nest_q [NestDepth];
    logic                 nest_d [NestDepth];
    logic [DepthWidth-1:0] depth_q, depth_d;
    logic [PrioWidth-1:0]  cur_level_q, cur_level_d;
    logic                  underflow_q, underflow_d;

    logic [PtrWidth-1:0]  top_idx;
    logic [PrioWidth-1:0] eff_level;
    logic                 eligible;
    logic                 take;

    assign req_in    = '{id: ctl.irq_id_i, level: ctl.irq_level_i,
                         heti: ctl.irq_heti_i, nest: ctl.irq_nest_i};
    assign top_idx   = PtrWidth'(depth_q - DepthWidth'(1));
    assign eff_level = (mthresh_i > cur_level_q) ? mthresh_i : cur_level_q;
    assign eligible  = ctl.irq_valid_i
                     && (ctl.irq_level_i > eff_level)
                     && (depth_q < DepthWidth'(NestDepth))
                     && ((depth_q == '0) || nest_q[top_idx]);
    assign take      = (state_q == REQ) && core_irq_ack_i;

    // Pop before push, so ack+mret on a non-empty stack replaces the top entry.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so each path reads the updated value and no latch is inferred.
        lvl_d       = lvl_q;
        nest_d      = nest_q;
        depth_d     = depth_q;
        underflow_d = underflow_q;
        if (core_mret_i) begin
            if (depth_q != '0) begin
                depth_d = depth_q - DepthWidth'(1);
            end else begin
                underflow_d = 1'b1;
            end
        end
        if (take) begin
            lvl_d[PtrWidth'(depth_d)]  = req_q.level;
            nest_d[PtrWidth'(depth_d)] = req_q.nest;
            depth_d                    = depth_d + DepthWidth'(1);
        end
        cur_level_d = (depth_d == '0) ? '0 : lvl_d[PtrWidth'(depth_d - DepthWidth'(1))];
    end

    always_ff @(posedge clk_i) begin
        // NOTE: stack storage is left unreset; depth_q alone decides which entries are valid.
        lvl_q  <= lvl_d;
        nest_q <= nest_d;
        if (rst_i) begin
            depth_q     <= '0;
            cur_level_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            cur_level_q <= cur_level_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            ack_id_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (eligible) begin
                        req_q       <= req_in;
                        req_valid_q <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (core_irq_ack_i) begin
                        ack_q       <= 1'b1;
                        ack_id_q    <= req_q.id;
                        req_valid_q <= 1'b0;
                        state_q     <= ACK;
                    end else if (!eligible) begin
                        req_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (ctl.irq_level_i > req_q.level) begin
                        req_q <= req_in;
                    end
                end
                // The controller's pending bit is still clearing here, so nothing is sampled.
                ACK: state_q <= IDLE;
                default: begin
                    req_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign core_irq_req_o   = req_valid_q;
    assign core_irq_id_o    = req_q.id;
    assign core_irq_level_o = req_q.level;
    assign core_irq_heti_o  = req_q.heti;
    assign ctl.irq_ack_o    = ack_q;
    assign ctl.irq_ack_id_o = ack_id_q;
    assign cur_level_o      = cur_level_q;
    assign depth_o          = depth_q;
    assign underflow_o      = underflow_q;
endmodule

// File: tb/tb_irq_preempt_ctrl.sv
// Bench for irq_preempt_ctrl: directed scenarios from the block's use cases plus a
// randomized run scored against a queue-based model of the preemption rules.
module tb_irq_preempt_ctrl;
    localparam int IW = 6;
    localparam int PW = 5;
    localparam int DW = 4;
    localparam int NEST_DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] mthresh;
    logic          core_ack;
    logic          core_mret;
    logic          core_req;
    logic [IW-1:0] core_id;
    logic [PW-1:0] core_level;
    logic          core_heti;
    logic [PW-1:0] cur_level;
    logic [DW-1:0] depth;
    logic          underflow;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    irq_preempt_ctrl_if #(.NrIrqLines(64), .NrIrqPrios(32)) ctl_if ();

    irq_preempt_ctrl #(.NrIrqLines(64), .NrIrqPrios(32), .NestDepth(NEST_DEPTH)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ctl              (ctl_if),
        .mthresh_i        (mthresh),
        .core_irq_req_o   (core_req),
        .core_irq_id_o    (core_id),
        .core_irq_level_o (core_level),
        .core_irq_heti_o  (core_heti),
        .core_irq_ack_i   (core_ack),
        .core_mret_i      (core_mret),
        .cur_level_o      (cur_level),
        .depth_o          (depth),
        .underflow_o      (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: handler stack as a queue, request state derived from its own outputs.
    typedef struct {
        int level;
        bit nest;
    } ent_t;

    ent_t m_stk[$];
    bit   m_req, m_heti, m_nest, m_ack, m_uf;
    int   m_id, m_level, m_ack_id;

    function automatic int m_cur();
        return (m_stk.size() == 0) ? 0 : m_stk[$].level;
    endfunction

    function automatic bit m_eligible();
        int eff;
        eff = (int'(mthresh) > m_cur()) ? int'(mthresh) : m_cur();
        return ctl_if.irq_valid_i && (int'(ctl_if.irq_level_i) > eff)
            && (m_stk.size() < NEST_DEPTH) && (m_stk.size() == 0 || m_stk[$].nest);
    endfunction

    task automatic model_step();
        bit elig, take, was_ack;
        ent_t e;
        if (rst) begin
            m_stk.delete();
            m_req = 0; m_heti = 0; m_nest = 0; m_ack = 0; m_uf = 0;
            m_id = 0; m_level = 0; m_ack_id = 0;
            return;
        end
        elig    = m_eligible();
        take    = m_req && core_ack;
        was_ack = m_ack;
        if (core_mret) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else m_uf = 1;
        end
        if (take) begin
            e.level = m_level;
            e.nest  = m_nest;
            m_stk.push_back(e);
            m_ack_id = m_id;
        end
        m_ack = take;
        if (take) begin
            m_req = 0;
        end else if (m_req) begin
            if (!elig) m_req = 0;
            else if (int'(ctl_if.irq_level_i) > m_level) begin
                m_id = ctl_if.irq_id_i; m_level = ctl_if.irq_level_i;
                m_heti = ctl_if.irq_heti_i; m_nest = ctl_if.irq_nest_i;
            end
        end else if (!was_ack && elig) begin
            m_req = 1;
            m_id = ctl_if.irq_id_i; m_level = ctl_if.irq_level_i;
            m_heti = ctl_if.irq_heti_i; m_nest = ctl_if.irq_nest_i;
        end
    endtask

    // Inputs change on the falling edge; outputs are read there too, clear of the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_irq(input bit v, input int id, input int lvl, input bit heti, input bit nest);
        ctl_if.irq_valid_i = v;
        ctl_if.irq_id_i    = IW'(id);
        ctl_if.irq_level_i = PW'(lvl);
        ctl_if.irq_heti_i  = heti;
        ctl_if.irq_nest_i  = nest;
    endtask

    task automatic do_reset();
        set_irq(0, 0, 0, 0, 0);
        mthresh = '0; core_ack = 0; core_mret = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic take_irq(input int id, input int lvl, input bit nest);
        set_irq(1, id, lvl, 0, nest);
        tick();
        set_irq(0, 0, 0, 0, 0);
        core_ack = 1;
        tick();
        core_ack = 0;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] got;
        do_reset();
        got = {core_req, core_id, core_level, core_heti, ctl_if.irq_ack_o,
               ctl_if.irq_ack_id_o, cur_level, depth, underflow};
        chk_cnt++;
        if (got !== '0) $display("FAIL reset_outputs got %h want 0", got);
        else pass_cnt++;
    endtask

    task automatic test_basic_take();
        do_reset();
        set_irq(1, 5, 3, 1, 1);
        tick();
        chk_cnt++;
        if ({core_req, core_id, core_level, core_heti} !== {1'b1, 6'd5, 5'd3, 1'b1})
            $display("FAIL basic_req got req=%0b id=%0d lvl=%0d heti=%0b want 1/5/3/1",
                     core_req, core_id, core_level, core_heti);
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if (core_req !== 1'b1 || ctl_if.irq_ack_o !== 1'b0)
            $display("FAIL basic_hold got req=%0b ack=%0b want 1/0", core_req, ctl_if.irq_ack_o);
        else pass_cnt++;
        core_ack = 1;
        set_irq(0, 0, 0, 0, 0);
        tick();
        core_ack = 0;
        chk_cnt++;
        if ({ctl_if.irq_ack_o, ctl_if.irq_ack_id_o, core_req, depth, cur_level} !==
            {1'b1, 6'd5, 1'b0, 4'd1, 5'd3})
            $display("FAIL basic_ack got ack=%0b id=%0d req=%0b depth=%0d cur=%0d want 1/5/0/1/3",
                     ctl_if.irq_ack_o, ctl_if.irq_ack_id_o, core_req, depth, cur_level);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (ctl_if.irq_ack_o !== 1'b0 || depth !== 4'd1)
            $display("FAIL basic_ack_pulse got ack=%0b depth=%0d want 0/1", ctl_if.irq_ack_o, depth);
        else pass_cnt++;
    endtask

    task automatic test_preempt();
        do_reset();
        take_irq(1, 3, 1);
        set_irq(1, 4, 3, 0, 1);
        tick();
        chk_cnt++;
        if (core_req !== 1'b0) $display("FAIL preempt_equal got req=%0b want 0", core_req);
        else pass_cnt++;
        set_irq(1, 4, 4, 0, 1);
        tick();
        chk_cnt++;
        if (core_req !== 1'b1 || core_level !== 5'd4)
            $display("FAIL preempt_higher got req=%0b lvl=%0d want 1/4", core_req, core_level);
        else pass_cnt++;
        do_reset();
        take_irq(2, 3, 0);
        set_irq(1, 6, 7, 0, 1);
        tick();
        tick();
        chk_cnt++;
        if (core_req !== 1'b0) $display("FAIL preempt_nonest got req=%0b want 0", core_req);
        else pass_cnt++;
    endtask

    task automatic test_retarget_withdraw();
        do_reset();
        set_irq(1, 2, 4, 0, 1);
        tick();
        chk_cnt++;
        if (core_req !== 1'b1 || core_id !== 6'd2)
            $display("FAIL retarget_first got req=%0b id=%0d want 1/2", core_req, core_id);
        else pass_cnt++;
        set_irq(1, 9, 6, 1, 0);
        tick();
        chk_cnt++;
        if ({core_req, core_id, core_level, core_heti} !== {1'b1, 6'd9, 5'd6, 1'b1})
            $display("FAIL retarget_new got req=%0b id=%0d lvl=%0d heti=%0b want 1/9/6/1",
                     core_req, core_id, core_level, core_heti);
        else pass_cnt++;
        set_irq(0, 0, 0, 0, 0);
        tick();
        chk_cnt++;
        if (core_req !== 1'b0 || ctl_if.irq_ack_o !== 1'b0)
            $display("FAIL withdraw got req=%0b ack=%0b want 0/0", core_req, ctl_if.irq_ack_o);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (ctl_if.irq_ack_o !== 1'b0 || depth !== 4'd0)
            $display("FAIL withdraw_noack got ack=%0b depth=%0d want 0/0", ctl_if.irq_ack_o, depth);
        else pass_cnt++;
    endtask

    task automatic test_threshold();
        do_reset();
        mthresh = 5'd10;
        set_irq(1, 3, 10, 0, 1);
        tick();
        chk_cnt++;
        if (core_req !== 1'b0) $display("FAIL thresh_equal got req=%0b want 0", core_req);
        else pass_cnt++;
        set_irq(1, 3, 11, 0, 1);
        tick();
        chk_cnt++;
        if (core_req !== 1'b1) $display("FAIL thresh_above got req=%0b want 1", core_req);
        else pass_cnt++;
        set_irq(0, 0, 0, 0, 0);
        mthresh = '0;
        tick();
    endtask

    task automatic test_full_stack();
        do_reset();
        for (int l = 1; l <= NEST_DEPTH; l++) take_irq(l, l, 1);
        chk_cnt++;
        if (depth !== 4'd8 || cur_level !== 5'd8)
            $display("FAIL full_depth got depth=%0d cur=%0d want 8/8", depth, cur_level);
        else pass_cnt++;
        set_irq(1, 20, 9, 0, 1);
        tick();
        tick();
        chk_cnt++;
        if (core_req !== 1'b0) $display("FAIL full_blocked got req=%0b want 0", core_req);
        else pass_cnt++;
        core_mret = 1;
        tick();
        core_mret = 0;
        chk_cnt++;
        if (depth !== 4'd7 || cur_level !== 5'd7)
            $display("FAIL full_pop got depth=%0d cur=%0d want 7/7", depth, cur_level);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (core_req !== 1'b1 || core_id !== 6'd20)
            $display("FAIL full_reopen got req=%0b id=%0d want 1/20", core_req, core_id);
        else pass_cnt++;
        set_irq(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_corners();
        do_reset();
        core_mret = 1;
        tick();
        core_mret = 0;
        chk_cnt++;
        if (underflow !== 1'b1 || depth !== 4'd0)
            $display("FAIL underflow_set got uf=%0b depth=%0d want 1/0", underflow, depth);
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if (underflow !== 1'b1) $display("FAIL underflow_sticky got %0b want 1", underflow);
        else pass_cnt++;
        do_reset();
        chk_cnt++;
        if (underflow !== 1'b0) $display("FAIL underflow_clear got %0b want 0", underflow);
        else pass_cnt++;
        take_irq(1, 2, 1);
        take_irq(2, 5, 1);
        set_irq(1, 7, 9, 0, 1);
        tick();
        set_irq(0, 0, 0, 0, 0);
        core_ack = 1;
        core_mret = 1;
        tick();
        core_ack = 0;
        core_mret = 0;
        chk_cnt++;
        if ({depth, cur_level, ctl_if.irq_ack_o, ctl_if.irq_ack_id_o} !== {4'd2, 5'd9, 1'b1, 6'd7})
            $display("FAIL tailchain got depth=%0d cur=%0d ack=%0b id=%0d want 2/9/1/7",
                     depth, cur_level, ctl_if.irq_ack_o, ctl_if.irq_ack_id_o);
        else pass_cnt++;
        core_mret = 1;
        tick();
        core_mret = 0;
        chk_cnt++;
        if (depth !== 4'd1 || cur_level !== 5'd2)
            $display("FAIL tailchain_below got depth=%0d cur=%0d want 1/2", depth, cur_level);
        else pass_cnt++;
        set_irq(1, 11, 5, 1, 1);
        tick();
        rst = 1;
        tick();
        chk_cnt++;
        if ({core_req, core_id, core_level, core_heti, ctl_if.irq_ack_o, cur_level, depth} !== '0)
            $display("FAIL reset_in_req got req=%0b id=%0d lvl=%0d depth=%0d want all 0",
                     core_req, core_id, core_level, depth);
        else pass_cnt++;
        rst = 0;
        set_irq(0, 0, 0, 0, 0);
        core_ack = 1;
        tick();
        core_ack = 0;
        chk_cnt++;
        if (ctl_if.irq_ack_o !== 1'b0 || core_req !== 1'b0 || depth !== 4'd0)
            $display("FAIL reset_no_ack got ack=%0b req=%0b depth=%0d want 0/0/0",
                     ctl_if.irq_ack_o, core_req, depth);
        else pass_cnt++;
    endtask

    task automatic test_random(input int n);
        logic [63:0] got, exp;
        do_reset();
        for (int i = 0; i < n; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) mthresh = PW'($urandom_range(0, 6));
            set_irq($urandom_range(0, 9) < 7, $urandom_range(0, 63), $urandom_range(0, 31),
                    $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            core_ack  = ($urandom_range(0, 9) < 4);
            core_mret = ($urandom_range(0, 9) < 2);
            tick();
            got = {core_req, ctl_if.irq_ack_o, cur_level, depth, underflow,
                   m_req ? {core_id, core_level, core_heti} : 12'd0,
                   m_ack ? ctl_if.irq_ack_id_o : 6'd0};
            exp = {m_req, m_ack, PW'(m_cur()), DW'(m_stk.size()), m_uf,
                   m_req ? {IW'(m_id), PW'(m_level), m_heti} : 12'd0,
                   m_ack ? IW'(m_ack_id) : 6'd0};
            chk_cnt++;
            if (got !== exp) $display("FAIL random cycle %0d got %h want %h", i, got, exp);
            else pass_cnt++;
        end
        rst = 0;
        core_ack = 0;
        core_mret = 0;
        set_irq(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1;
        mthresh = '0;
        core_ack = 0;
        core_mret = 0;
        set_irq(0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_basic_take();
        test_preempt();
        test_retarget_withdraw();
        test_threshold();
        test_full_stack();
        test_corners();
        test_random(3000);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
